// File: rtl/cpu_pkg.sv
// Shared front-end definitions: default datapath widths and the {pc, instr} record
// carried from fetch toward decode.
package cpu_pkg;
    localparam int unsigned DEF_PC_W    = 19;
    localparam int unsigned DEF_INSTR_W = 32;

    typedef struct packed {
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with clear; the head entry is presented straight
// from the storage registers so consumers see no combinational path from push.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned W     = DEF_PC_W + DEF_INSTR_W,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign do_pop     = pop && head_valid;
    assign do_push    = push && !clear;

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
        if (rstn && do_push && !do_pop)
            overflow_chk: assert (count != CNT_W'(DEPTH));
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC register, fixed-latency in-flight tracking,
// credit-based issue and redirect flush, feeding a {pc, instr} FIFO toward decode.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned      PC_W     = DEF_PC_W,
    parameter int unsigned      INSTR_W  = DEF_INSTR_W,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      MEM_LAT  = 1,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = $clog2(DEPTH + MEM_LAT + 1);

    logic [PC_W-1:0]         pc_reg;
    logic                    slot_v  [MEM_LAT];
    logic [PC_W-1:0]         slot_pc [MEM_LAT];
    logic [SUM_W-1:0]        inflight;
    logic [CNT_W-1:0]        count;
    logic                    issue;
    logic                    ret_valid;
    logic [PC_W+INSTR_W-1:0] head_data;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < MEM_LAT; i++)
            inflight = inflight + SUM_W'(slot_v[i]);
    end

    // Buffered plus in-flight entries never exceed DEPTH, so every return has a slot.
    assign issue     = fetch_en && !redirect_valid &&
                       ((SUM_W'(count) + inflight) < SUM_W'(DEPTH));
    assign imem_en   = issue;
    assign imem_addr = pc_reg;
    assign ret_valid = slot_v[MEM_LAT-1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_reg <= RESET_PC;
            for (int unsigned i = 0; i < MEM_LAT; i++) slot_v[i] <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg <= redirect_pc;
            for (int unsigned i = 0; i < MEM_LAT; i++) slot_v[i] <= 1'b0;
        end else begin
            if (issue) pc_reg <= pc_reg + PC_W'(1);
            slot_v[0]  <= issue;
            slot_pc[0] <= pc_reg;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                slot_v[i]  <= slot_v[i-1];
                slot_pc[i] <= slot_pc[i-1];
            end
        end
    end

    fetch_fifo #(
        .W     (PC_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (redirect_valid),
        .push       (ret_valid),
        .push_data  ({slot_pc[MEM_LAT-1], imem_rdata}),
        .pop        (out_valid && out_ready),
        .head_valid (out_valid),
        .head_data  (head_data),
        .count      (count)
    );

    assign out_pc    = head_data[PC_W+INSTR_W-1:INSTR_W];
    assign out_instr = head_data[INSTR_W-1:0];
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: one instance at MEM_LAT=1 and one at MEM_LAT=3,
// each backed by a behavioural fixed-latency instruction memory.
module tb_fetch_queue;
    import cpu_pkg::*;

    localparam int unsigned PW = 19;
    localparam int unsigned IW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn1, rstn3, fetch_en, redirect_valid, out_ready;
    logic [PW-1:0] redirect_pc;
    logic          en1, en3, v1, v3;
    logic [PW-1:0] addr1, addr3, pc1, pc3;
    logic [IW-1:0] rdata1, rdata3, instr1, instr3;

    fetch_queue #(.PC_W(PW), .INSTR_W(IW), .DEPTH(4), .MEM_LAT(1), .RESET_PC('0)) dut1 (
        .clk(clk), .rstn(rstn1), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_en(en1), .imem_addr(addr1), .imem_rdata(rdata1),
        .out_valid(v1), .out_ready(out_ready), .out_pc(pc1), .out_instr(instr1)
    );

    fetch_queue #(.PC_W(PW), .INSTR_W(IW), .DEPTH(4), .MEM_LAT(3), .RESET_PC('0)) dut3 (
        .clk(clk), .rstn(rstn3), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_en(en3), .imem_addr(addr3), .imem_rdata(rdata3),
        .out_valid(v3), .out_ready(out_ready), .out_pc(pc3), .out_instr(instr3)
    );

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        return {13'h15A3, a};
    endfunction

    logic [IW-1:0] pipe1;
    logic [IW-1:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= en1 ? mem_word(addr1) : 32'hDEADBEEF;
        pipe3[0] <= en3 ? mem_word(addr3) : 32'hDEADBEEF;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign rdata1 = pipe1;
    assign rdata3 = pipe3[2];

    int            sel;
    logic          o_valid, m_en;
    logic [PW-1:0] o_pc, m_addr;
    logic [IW-1:0] o_instr;
    always_comb begin
        o_valid = (sel == 3) ? v3     : v1;
        o_pc    = (sel == 3) ? pc3    : pc1;
        o_instr = (sel == 3) ? instr3 : instr1;
        m_en    = (sel == 3) ? en3    : en1;
        m_addr  = (sel == 3) ? addr3  : addr1;
    end

    int            checks = 0;
    int            errors = 0;
    bit            mon_on;
    logic [PW-1:0] exp_pc;
    fetch_entry_t  seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle_begin();
        @(posedge clk);
        #1;
    endtask

    // Every accepted head must be the next PC in program order with its memory word.
    task automatic sample();
        @(negedge clk);
        if (mon_on && o_valid && out_ready) begin
            seen = '{pc: o_pc, instr: o_instr};
            check("deliver_pc", 64'(seen.pc), 64'(exp_pc));
            check("deliver_instr", 64'(seen.instr), 64'(mem_word(exp_pc)));
            exp_pc = exp_pc + PW'(1);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_begin();
            sample();
        end
    endtask

    initial begin
        rstn1 = 1'b0; rstn3 = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b0; mon_on = 1'b0; sel = 1; exp_pc = '0;
        repeat (2) cycle_begin();
        sample();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_en",    64'(m_en),    64'd0);
        check("rst_addr",  64'(m_addr),  64'd0);

        // streaming, MEM_LAT=1
        cycle_begin(); rstn1 = 1'b1; fetch_en = 1'b1; out_ready = 1'b1; mon_on = 1'b1;
        sample();
        check("c0_en", 64'(m_en), 64'd1);
        check("c0_addr", 64'(m_addr), 64'd0);
        check("c0_valid", 64'(o_valid), 64'd0);
        for (int k = 1; k < 10; k++) begin
            cycle_begin(); sample();
            check("seq_en", 64'(m_en), 64'd1);
            check("seq_addr", 64'(m_addr), 64'(k));
            check("seq_valid", 64'(o_valid), 64'(k >= 2));
        end

        // backpressure: issue stops once 4 entries are owed
        for (int k = 0; k < 10; k++) begin
            cycle_begin(); out_ready = 1'b0; sample();
            check("bp_en", 64'(m_en), 64'(k < 2));
            check("bp_addr", 64'(m_addr), (k < 2) ? 64'(10 + k) : 64'd12);
            check("bp_valid", 64'(o_valid), 64'd1);
        end
        check("bp_head", 64'(o_pc), 64'd8);
        for (int k = 0; k < 8; k++) begin
            cycle_begin(); out_ready = 1'b1; sample();
            check("rel_valid", 64'(o_valid), 64'd1);
            if (k < 2) begin
                check("rel_en", 64'(m_en), 64'(k == 1));
                check("rel_addr", 64'(m_addr), 64'd12);
            end
        end

        // redirect with 3 buffered, 1 in flight
        cycle_begin(); out_ready = 1'b0; sample();
        check("pre_rd_addr", 64'(m_addr), 64'd19);
        cycle_begin(); redirect_valid = 1'b1; redirect_pc = 19'h01F00; sample();
        check("rd_en", 64'(m_en), 64'd0);
        check("rd_head", 64'(o_pc), 64'd16);
        cycle_begin(); redirect_valid = 1'b0; out_ready = 1'b1; exp_pc = 19'h01F00; sample();
        check("rd1_valid", 64'(o_valid), 64'd0);
        check("rd1_en", 64'(m_en), 64'd1);
        check("rd1_addr", 64'(m_addr), 64'h1F00);
        cycle_begin(); sample();
        check("rd2_valid", 64'(o_valid), 64'd0);
        check("rd2_addr", 64'(m_addr), 64'h1F01);
        cycle_begin(); sample();
        check("rd3_valid", 64'(o_valid), 64'd1);
        check("rd3_pc", 64'(o_pc), 64'h1F00);
        run(3);

        // redirect coinciding with a pop and a returning datum
        cycle_begin(); redirect_valid = 1'b1; redirect_pc = 19'h00100; sample();
        check("rp_en", 64'(m_en), 64'd0);
        check("rp_head", 64'(o_pc), 64'h1F04);
        cycle_begin(); redirect_valid = 1'b0; exp_pc = 19'h00100; sample();
        check("rp1_valid", 64'(o_valid), 64'd0);
        check("rp1_addr", 64'(m_addr), 64'h100);
        cycle_begin(); sample();
        check("rp2_valid", 64'(o_valid), 64'd0);
        cycle_begin(); sample();
        check("rp3_pc", 64'(o_pc), 64'h100);
        run(1);

        // PC wrap
        cycle_begin(); redirect_valid = 1'b1; redirect_pc = 19'h7FFFF; sample();
        cycle_begin(); redirect_valid = 1'b0; exp_pc = 19'h7FFFF; sample();
        check("wrap_en", 64'(m_en), 64'd1);
        check("wrap_addr0", 64'(m_addr), 64'h7FFFF);
        cycle_begin(); sample();
        check("wrap_addr1", 64'(m_addr), 64'd0);
        cycle_begin(); sample();
        check("wrap_pc0", 64'(o_pc), 64'h7FFFF);
        cycle_begin(); sample();
        check("wrap_pc1", 64'(o_pc), 64'd0);

        // reset with a full FIFO
        for (int k = 0; k < 6; k++) begin
            cycle_begin(); out_ready = 1'b0; sample();
        end
        check("full_en", 64'(m_en), 64'd0);
        check("full_head", 64'(o_pc), 64'd1);
        cycle_begin(); rstn1 = 1'b0; sample();
        cycle_begin(); rstn1 = 1'b1; out_ready = 1'b1; exp_pc = '0; sample();
        check("mrst_valid", 64'(o_valid), 64'd0);
        check("mrst_addr", 64'(m_addr), 64'd0);
        check("mrst_en", 64'(m_en), 64'd1);
        cycle_begin(); sample();
        check("mrst1_valid", 64'(o_valid), 64'd0);
        cycle_begin(); sample();
        check("mrst2_pc", 64'(o_pc), 64'd0);
        run(3);

        // MEM_LAT=3 instance
        cycle_begin(); mon_on = 1'b0; rstn1 = 1'b0; fetch_en = 1'b0; out_ready = 1'b0; sel = 3;
        cycle_begin(); sample();
        check("l3_rst_valid", 64'(o_valid), 64'd0);
        check("l3_rst_en", 64'(m_en), 64'd0);
        check("l3_rst_addr", 64'(m_addr), 64'd0);
        cycle_begin(); rstn3 = 1'b1; fetch_en = 1'b1; sample();
        check("l3_d0_en", 64'(m_en), 64'd1);
        check("l3_d0_addr", 64'(m_addr), 64'd0);
        for (int k = 1; k < 6; k++) begin
            cycle_begin(); sample();
            check("l3_en", 64'(m_en), 64'(k < 4));
            check("l3_addr", 64'(m_addr), (k < 4) ? 64'(k) : 64'd4);
            check("l3_valid", 64'(o_valid), 64'(k >= 4));
        end
        cycle_begin(); redirect_valid = 1'b1; redirect_pc = 19'h01F00; sample();
        check("l3_rd_en", 64'(m_en), 64'd0);
        check("l3_rd_head", 64'(o_pc), 64'd0);
        cycle_begin(); redirect_valid = 1'b0; out_ready = 1'b1; exp_pc = 19'h01F00; mon_on = 1'b1;
        sample();
        check("l3_rd1_en", 64'(m_en), 64'd1);
        check("l3_rd1_addr", 64'(m_addr), 64'h1F00);
        check("l3_rd1_valid", 64'(o_valid), 64'd0);
        for (int k = 1; k < 4; k++) begin
            cycle_begin(); sample();
            check("l3_wait_valid", 64'(o_valid), 64'd0);
            check("l3_wait_addr", 64'(m_addr), 64'(32'h1F00 + k));
        end
        cycle_begin(); sample();
        check("l3_first_valid", 64'(o_valid), 64'd1);
        check("l3_first_pc", 64'(o_pc), 64'h1F00);
        run(14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
